// File: rtl/stopwatch_counter.sv
// BCD MM:SS stopwatch core with pause, per-field adjust and an adjust blink mask.
// Divider clocks are used as level enables and are edge-detected in the clk domain.
module stopwatch_counter #(
  parameter int MIN_MAX = 99,
  parameter int SEC_MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clock1Hz,
  input  logic       clock2Hz,
  input  logic       clockBlink,
  input  logic       pause,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] digit_blank,
  output logic       paused
);

  typedef enum logic {RUN = 1'b0, PAUSED = 1'b1} state_t;

  localparam logic [7:0] MIN_LIM = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};
  localparam logic [7:0] SEC_LIM = {4'(SEC_MAX / 10), 4'(SEC_MAX % 10)};

  // Two-digit BCD increment that wraps to 00 after lim.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    logic [7:0] r;
    if (v == lim)             r = '0;
    else if (v[3:0] == 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
    else                      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  state_t     state_q, state_d;
  logic       c1_prev_q, c1_prev_d;
  logic       c2_prev_q, c2_prev_d;
  logic       p_prev_q, p_prev_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic [3:0] blank_q, blank_d;

  logic tick1, tick2, ptog;

  // Edge detection, count/adjust update, run/pause toggle and blink mask.
  always_comb begin
    tick1     = clock1Hz & ~c1_prev_q;
    tick2     = clock2Hz & ~c2_prev_q;
    ptog      = pause & ~p_prev_q;
    c1_prev_d = clock1Hz;
    c2_prev_d = clock2Hz;
    p_prev_d  = pause;
    state_d   = state_q;
    min_d     = min_q;
    sec_d     = sec_q;
    blank_d   = '0;

    if (ptog) state_d = (state_q == RUN) ? PAUSED : RUN;

    if (!adj) begin
      if (state_q == RUN && tick1) begin
        sec_d = bcd_inc(sec_q, SEC_LIM);
        if (sec_q == SEC_LIM) min_d = bcd_inc(min_q, MIN_LIM);
      end
    end else if (tick2) begin
      if (sel) sec_d = bcd_inc(sec_q, SEC_LIM);
      else     min_d = bcd_inc(min_q, MIN_LIM);
    end

    if (adj) begin
      if (sel) blank_d = {2'b00, ~clockBlink, ~clockBlink};
      else     blank_d = {~clockBlink, ~clockBlink, 2'b00};
    end
  end

  // All state registers; asynchronous reset to 00:00, RUN, cleared history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      c1_prev_q <= 1'b0;
      c2_prev_q <= 1'b0;
      p_prev_q  <= 1'b0;
      min_q     <= '0;
      sec_q     <= '0;
      blank_q   <= '0;
    end else begin
      state_q   <= state_d;
      c1_prev_q <= c1_prev_d;
      c2_prev_q <= c2_prev_d;
      p_prev_q  <= p_prev_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      blank_q   <= blank_d;
    end
  end

  assign min_tens    = min_q[7:4];
  assign min_ones    = min_q[3:0];
  assign sec_tens    = sec_q[7:4];
  assign sec_ones    = sec_q[3:0];
  assign digit_blank = blank_q;
  assign paused      = (state_q == PAUSED);

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter against an integer minutes/seconds model.
module tb_stopwatch_counter;

  localparam int MIN_MAX = 99;
  localparam int SEC_MAX = 59;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clock1Hz = 1'b0, clock2Hz = 1'b0, clockBlink = 1'b0;
  logic pause = 1'b0, adj = 1'b0, sel = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones, digit_blank;
  logic paused;
  logic [15:0] dut_d;

  int passed = 0;
  int total  = 0;

  // Reference model state
  int   m_min, m_sec;
  bit   m_paused;
  bit   m_p1, m_p2, m_pp;
  logic [3:0] m_blank;

  stopwatch_counter #(.MIN_MAX(MIN_MAX), .SEC_MAX(SEC_MAX)) dut (
    .clk(clk), .rst(rst), .clock1Hz(clock1Hz), .clock2Hz(clock2Hz),
    .clockBlink(clockBlink), .pause(pause), .adj(adj), .sel(sel),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
    .sec_ones(sec_ones), .digit_blank(digit_blank), .paused(paused)
  );

  always #5 clk = ~clk;

  assign dut_d = {min_tens, min_ones, sec_tens, sec_ones};

  function automatic logic [15:0] exp_d();
    return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
  endfunction

  task automatic m_reset();
    m_min = 0; m_sec = 0; m_paused = 0;
    m_p1 = 0; m_p2 = 0; m_pp = 0; m_blank = 4'b0000;
  endtask

  // One clk: advance the model with the inputs seen at the edge, then settle.
  task automatic cyc();
    bit t1, t2, pt;
    @(posedge clk);
    if (rst) m_reset();
    else begin
      t1 = clock1Hz && !m_p1;
      t2 = clock2Hz && !m_p2;
      pt = pause && !m_pp;
      if (!adj && !m_paused && t1) begin
        m_sec = m_sec + 1;
        if (m_sec > SEC_MAX) begin
          m_sec = 0;
          m_min = (m_min + 1) % (MIN_MAX + 1);
        end
      end
      if (adj && t2) begin
        if (sel) m_sec = (m_sec + 1) % (SEC_MAX + 1);
        else     m_min = (m_min + 1) % (MIN_MAX + 1);
      end
      if (pt) m_paused = !m_paused;
      if (!adj)     m_blank = 4'b0000;
      else if (sel) m_blank = {2'b00, !clockBlink, !clockBlink};
      else          m_blank = {!clockBlink, !clockBlink, 2'b00};
      m_p1 = clock1Hz; m_p2 = clock2Hz; m_pp = pause;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pulse1();
    clock1Hz = 1'b1; cyc();
    clock1Hz = 1'b0; cyc();
    idle($urandom_range(0, 2));
  endtask

  task automatic pulse2();
    clock2Hz = 1'b1; cyc();
    clock2Hz = 1'b0; cyc();
    idle($urandom_range(0, 2));
  endtask

  task automatic do_reset();
    rst = 1'b1; m_reset();
    #2;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clock1Hz = 0; clock2Hz = 0; pause = 0; adj = 0; sel = 0; clockBlink = 0;
    do_reset();
    total++; if (dut_d !== 16'h0000) $display("FAIL reset_digits got %h exp 0000", dut_d); else passed++;
    total++; if (digit_blank !== 4'b0000) $display("FAIL reset_blank got %b exp 0000", digit_blank); else passed++;
    total++; if (paused !== 1'b0) $display("FAIL reset_paused got %b exp 0", paused); else passed++;
  endtask

  task automatic test_count61();
    clock1Hz = 1'b1; cyc();
    total++; if (dut_d !== 16'h0001) $display("FAIL first_tick_latency got %h exp 0001", dut_d); else passed++;
    clock1Hz = 1'b0; cyc();
    for (int i = 1; i < 61; i++) pulse1();
    total++; if (dut_d !== 16'h0101) $display("FAIL count61 got %h exp 0101", dut_d); else passed++;
    total++; if (dut_d !== exp_d()) $display("FAIL count61_model got %h exp %h", dut_d, exp_d()); else passed++;
    total++; if (paused !== 1'b0 || digit_blank !== 4'b0000)
      $display("FAIL count61_flags got %b/%b exp 0/0000", paused, digit_blank); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    adj = 1; sel = 0;
    for (int i = 0; i < 99; i++) pulse2();
    sel = 1;
    for (int i = 0; i < 58; i++) pulse2();
    total++; if (dut_d !== 16'h9958) $display("FAIL preload got %h exp 9958", dut_d); else passed++;
    adj = 0; cyc();
    pulse1();
    total++; if (dut_d !== 16'h9959) $display("FAIL wrap_9959 got %h exp 9959", dut_d); else passed++;
    pulse1();
    total++; if (dut_d !== 16'h0000) $display("FAIL wrap_0000 got %h exp 0000", dut_d); else passed++;
  endtask

  task automatic test_pause();
    for (int i = 0; i < 5; i++) pulse1();
    total++; if (dut_d !== 16'h0005) $display("FAIL run_to_5 got %h exp 0005", dut_d); else passed++;
    pause = 1; idle(10); pause = 0; cyc();
    total++; if (paused !== 1'b1) $display("FAIL pause_once got %b exp 1", paused); else passed++;
    for (int i = 0; i < 3; i++) pulse1();
    total++; if (dut_d !== 16'h0005) $display("FAIL paused_hold got %h exp 0005", dut_d); else passed++;
    pause = 1; cyc(); pause = 0; cyc();
    total++; if (paused !== 1'b0) $display("FAIL unpause got %b exp 0", paused); else passed++;
    pulse1();
    total++; if (dut_d !== 16'h0006) $display("FAIL resume got %h exp 0006", dut_d); else passed++;
  endtask

  task automatic test_adjust_sec();
    logic [15:0] exp_seq [3];
    exp_seq[0] = 16'h0059; exp_seq[1] = 16'h0000; exp_seq[2] = 16'h0001;
    adj = 1; sel = 1;
    for (int i = 0; i < 52; i++) pulse2();
    total++; if (dut_d !== 16'h0058) $display("FAIL adj_to_58 got %h exp 0058", dut_d); else passed++;
    for (int k = 0; k < 3; k++) begin
      pulse2();
      pulse1();
      total++; if (dut_d !== exp_seq[k]) $display("FAIL adj_sec_%0d got %h exp %h", k, dut_d, exp_seq[k]); else passed++;
    end
  endtask

  task automatic test_blink();
    adj = 1; sel = 0; clockBlink = 0; cyc();
    total++; if (digit_blank !== 4'b1100) $display("FAIL blink_min_off got %b exp 1100", digit_blank); else passed++;
    clockBlink = 1; cyc();
    total++; if (digit_blank !== 4'b0000) $display("FAIL blink_min_on got %b exp 0000", digit_blank); else passed++;
    sel = 1; clockBlink = 0; cyc();
    total++; if (digit_blank !== 4'b0011) $display("FAIL blink_sec_off got %b exp 0011", digit_blank); else passed++;
    adj = 0; cyc();
    total++; if (digit_blank !== 4'b0000) $display("FAIL blink_exit got %b exp 0000", digit_blank); else passed++;
  endtask

  task automatic test_simultaneous();
    clock1Hz = 0; clock2Hz = 0; pause = 0; adj = 0; idle(2);
    clock1Hz = 1; pause = 1; cyc();
    total++; if (dut_d !== exp_d() || paused !== 1'b1)
      $display("FAIL simul_tick_pause got %h/%b exp %h/1", dut_d, paused, exp_d()); else passed++;
    clock1Hz = 0; pause = 0; cyc();
    adj = 1; sel = 0; clock2Hz = 1; pause = 1; cyc();
    total++; if (dut_d !== exp_d() || paused !== 1'b0)
      $display("FAIL simul_adj_pause got %h/%b exp %h/0", dut_d, paused, exp_d()); else passed++;
    clock2Hz = 0; pause = 0; adj = 0; cyc();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clock1Hz   = 1'($urandom_range(0, 1));
      clock2Hz   = 1'($urandom_range(0, 1));
      clockBlink = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)  pause = ~pause;
      if ($urandom_range(0, 15) == 0) adj = ~adj;
      if ($urandom_range(0, 15) == 0) sel = ~sel;
      cyc();
      total++;
      if (dut_d !== exp_d() || digit_blank !== m_blank || paused !== m_paused)
        $display("FAIL random_%0d got %h/%b/%b exp %h/%b/%b", i, dut_d, digit_blank, paused,
                 exp_d(), m_blank, m_paused);
      else passed++;
    end
    clock1Hz = 0; clock2Hz = 0; pause = 0; adj = 0; sel = 0; idle(2);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 30; i++) pulse1();
    total++; if (dut_d !== 16'h0030) $display("FAIL run_to_30 got %h exp 0030", dut_d); else passed++;
    pause = 1; cyc(); pause = 0; clock1Hz = 1; cyc();
    rst = 1; m_reset();
    #2;
    total++; if (dut_d !== 16'h0000 || paused !== 1'b0)
      $display("FAIL async_reset got %h/%b exp 0000/0", dut_d, paused); else passed++;
    cyc();
    rst = 0;
    cyc();
    total++; if (dut_d !== exp_d()) $display("FAIL release_high got %h exp %h", dut_d, exp_d()); else passed++;
    idle(3);
    total++; if (dut_d !== exp_d()) $display("FAIL held_high got %h exp %h", dut_d, exp_d()); else passed++;
    clock1Hz = 0; cyc(); clock1Hz = 1; cyc();
    total++; if (dut_d !== exp_d()) $display("FAIL fresh_edge got %h exp %h", dut_d, exp_d()); else passed++;
    clock1Hz = 0; cyc();
  endtask

  initial begin
    m_reset();
    #2;
    test_reset();
    test_count61();
    test_wrap();
    test_pause();
    test_adjust_sec();
    test_blink();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
